// File: rtl/instr_mem_pkg.sv
// Shared types and helpers for the instruction memory: FSM states, the default
// NOP encoding and the byte-lane order used by both the loader and the fetch path.
package instr_mem_pkg;

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } imem_state_e;

  localparam logic [31:0] IMEM_NOP = 32'h00000013;

  // Bit offset within a 32-bit word of the byte stored at address base+lane.
  function automatic int unsigned lane_shift(input int unsigned lane, input bit big_endian);
    return big_endian ? (3 - lane) * 8 : lane * 8;
  endfunction

endpackage

// File: rtl/instr_mem_array.sv
// Word-organised byte store: lane k of entry i holds byte address 4*i+k.
// Optional macro IMEM_PARITY_EN adds one even-parity bit per byte.
module instr_mem_array #(
  parameter int DEPTH_BYTES = 256,
  parameter int WIDX        = $clog2(DEPTH_BYTES) - 2
) (
  input  logic                  i_clk,
  input  logic                  i_wr_en,
  input  logic [WIDX-1:0]       i_wr_idx,
  input  logic [3:0][7:0]       i_wr_bytes,
  input  logic                  i_rd_en,
  input  logic [WIDX-1:0]       i_rd_idx,
  output logic [3:0][7:0]       o_rd_bytes
`ifdef IMEM_PARITY_EN
  ,
  output logic                  o_par_bad
`endif
);

  localparam int WORDS = DEPTH_BYTES / 4;

  // No reset on the storage: contents must survive nReset.
  logic [3:0][7:0] r_mem [WORDS];
  logic [3:0][7:0] r_rd_bytes;

  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_idx] <= i_wr_bytes;
    if (i_rd_en) r_rd_bytes <= r_mem[i_rd_idx];
  end

  assign o_rd_bytes = r_rd_bytes;

`ifdef IMEM_PARITY_EN
  logic [3:0] r_par [WORDS];
  logic [3:0] r_rd_par;
  logic [3:0] w_wr_par;

  always_comb begin
    w_wr_par = '0;
    for (int k = 0; k < 4; k++) w_wr_par[k] = ^i_wr_bytes[k];
  end

  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_par[i_wr_idx] <= w_wr_par;
    if (i_rd_en) r_rd_par <= r_par[i_rd_idx];
  end

  always_comb begin
    o_par_bad = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if ((^r_rd_bytes[k]) != r_rd_par[k]) o_par_bad = 1'b1;
    end
  end
`endif

endmodule

// File: rtl/instr_mem.sv
// Boot-loadable instruction memory with registered fetch, stall/squash and fault flags.
// Optional macro IMEM_PARITY_EN adds per-byte parity and the parity_err output.
module instr_mem
  import instr_mem_pkg::*;
#(
  parameter int          DEPTH_BYTES = 256,
  parameter bit          BIG_ENDIAN  = 1'b1,
  parameter logic [31:0] NOP_INSTR   = IMEM_NOP
) (
  input  logic        Clock,
  input  logic        nReset,
  input  logic [31:0] PC,
  input  logic        hold,
  input  logic        flush,
  input  logic        load_en,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
  input  logic        load_done,
  output logic [31:0] instruction,
  output logic        instr_valid,
  output logic        ready,
  output logic        misaligned,
  output logic        out_of_range,
  output logic        load_err,
`ifdef IMEM_PARITY_EN
  output logic        parity_err,
`endif
  output imem_state_e o_dbg_state
);

  localparam int AW   = $clog2(DEPTH_BYTES);
  localparam int WIDX = AW - 2;

  imem_state_e r_state, w_state_nxt;
  logic r_fetched, r_mis, r_oor, r_load_err;
  logic w_boot, w_load_bad, w_pc_mis, w_pc_oor, w_wr_en, w_rd_en, w_par_bad;
  logic [3:0][7:0] w_wr_bytes, w_rd_bytes;
  logic [31:0] w_word;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) r_state <= ST_BOOT;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == ST_BOOT && load_done) w_state_nxt = ST_RUN;
  end

  // 33-bit sums so addresses near 2^32 land in out_of_range instead of wrapping.
  assign w_boot     = (r_state == ST_BOOT);
  assign w_load_bad = (load_addr[1:0] != 2'b00) ||
                      (({1'b0, load_addr} + 33'd3) >= 33'(DEPTH_BYTES));
  assign w_pc_mis   = (PC[1:0] != 2'b00);
  assign w_pc_oor   = (({1'b0, PC} + 33'd3) >= 33'(DEPTH_BYTES));
  assign w_wr_en    = w_boot && load_en && !w_load_bad && nReset;
  assign w_rd_en    = !w_boot && !flush && !hold && !w_pc_mis && !w_pc_oor;

  always_comb begin
    w_wr_bytes = '0;
    w_word     = '0;
    for (int k = 0; k < 4; k++) begin
      w_wr_bytes[k] = 8'(load_data >> lane_shift(k, BIG_ENDIAN));
      w_word        = w_word | (32'(w_rd_bytes[k]) << lane_shift(k, BIG_ENDIAN));
    end
  end

  instr_mem_array #(
    .DEPTH_BYTES (DEPTH_BYTES),
    .WIDX        (WIDX)
  ) u_array (
    .i_clk      (Clock),
    .i_wr_en    (w_wr_en),
    .i_wr_idx   (load_addr[AW-1:2]),
    .i_wr_bytes (w_wr_bytes),
    .i_rd_en    (w_rd_en),
    .i_rd_idx   (PC[AW-1:2]),
`ifdef IMEM_PARITY_EN
    .o_par_bad  (w_par_bad),
`endif
    .o_rd_bytes (w_rd_bytes)
  );

`ifndef IMEM_PARITY_EN
  assign w_par_bad = 1'b0;
`endif

  // Flag registers sample at the same edge as the array read; hold freezes both.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_fetched  <= 1'b0;
      r_mis      <= 1'b0;
      r_oor      <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_load_err <= w_boot && load_en && w_load_bad;
      if (w_boot || flush) begin
        r_fetched <= 1'b0;
        r_mis     <= 1'b0;
        r_oor     <= 1'b0;
      end else if (!hold) begin
        r_fetched <= !w_pc_mis && !w_pc_oor;
        r_mis     <= w_pc_mis;
        r_oor     <= w_pc_oor;
      end
    end
  end

  assign instr_valid  = r_fetched && !w_par_bad;
  assign instruction  = instr_valid ? w_word : NOP_INSTR;
  assign ready        = (r_state == ST_RUN);
  assign misaligned   = r_mis;
  assign out_of_range = r_oor;
  assign load_err     = r_load_err;
  assign o_dbg_state  = r_state;
`ifdef IMEM_PARITY_EN
  assign parity_err   = r_fetched && w_par_bad;
`endif

endmodule

// File: doc/instr_mem.md
INSTR_MEM -- requirements
Module: instr_mem

Interface
REQ-001 The block SHALL have parameter DEPTH_BYTES, default 256, the memory size in bytes, a power of two and at least 8.
REQ-002 The block SHALL have parameter BIG_ENDIAN, default 1: 1 means byte PC holds instruction[31:24]; 0 means byte PC holds instruction[7:0].
REQ-003 The block SHALL have parameter NOP_INSTR, default 32'h00000013 (addi x0,x0,0).
REQ-004 The block SHALL have port Clock, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port nReset, input, 1 bit, reset; asynchronous, active-low.
REQ-006 The block SHALL have ports: PC in 32 (fetch byte address); hold in 1 (stall); flush in 1 (squash).
REQ-007 The block SHALL have loader ports: load_en in 1; load_addr in 32 (byte address); load_data in 32; load_done in 1.
REQ-008 The block SHALL have outputs: instruction out 32; instr_valid out 1; ready out 1 (state RUN); misaligned out 1; out_of_range out 1; load_err out 1.
REQ-009 With IMEM_PARITY_EN, the block SHALL additionally have output parity_err, 1 bit.

Function
REQ-010 Two states: BOOT and RUN. Reset enters BOOT. BOOT -> RUN on a clock edge where load_done=1. RUN has no exit except reset.
REQ-011 In BOOT, a load_en=1 edge SHALL write load_data to bytes load_addr..load_addr+3, in the order set by BIG_ENDIAN.
REQ-012 If load_en and load_done are high together, the write SHALL complete and the state SHALL still move to RUN.
REQ-013 A load with load_addr[1:0]!=0 or load_addr+3 >= DEPTH_BYTES SHALL be dropped; load_err pulses for exactly one cycle.
REQ-014 In RUN, load_en SHALL be ignored, with no write and no load_err.
REQ-015 While in BOOT, the outputs SHALL be instruction=NOP_INSTR and instr_valid=0, with all fault flags at 0.
REQ-016 In RUN, the edge action SHALL follow this priority: flush, then hold, then fetch.
REQ-017 Flush: instruction=NOP_INSTR, instr_valid=0, fault flags=0. Flush wins when flush and hold are both high.
REQ-018 Hold: instruction, instr_valid and all fault flags SHALL keep their values. This is a true stall, not NOP insertion.
REQ-019 Fetch: the registered outputs SHALL reflect the PC sampled at the same edge, giving one-cycle latency.
REQ-020 misaligned = (PC[1:0]!=0); out_of_range = (PC+3 >= DEPTH_BYTES). Both flags may be set together.
REQ-021 On any fault, instruction SHALL be NOP_INSTR and instr_valid SHALL be 0.
REQ-022 Address arithmetic SHALL use at least 33 bits so that PC near 2^32 wraps into out_of_range, never into a valid index.
REQ-023 The memory array SHALL have no reset; its contents survive nReset.

Reset
REQ-024 When nReset=0, the following SHALL take effect immediately and asynchronously: state=BOOT, instruction=NOP_INSTR, instr_valid=0, ready=0, every flag=0.
REQ-025 Reset asserted mid-fetch or mid-load SHALL abandon the operation. A load write on the same edge as reset assertion is not performed.

Configuration
REQ-026 With macro IMEM_PARITY_EN defined, the block SHALL store one even-parity bit per byte, computed on load.
REQ-027 With IMEM_PARITY_EN, a fetch reading any byte with bad parity SHALL set parity_err=1 and output NOP_INSTR with instr_valid=0. parity_err holds under hold like the other flags.
REQ-028 Without the macro, there SHALL be no parity storage and no parity_err port.

Structure
REQ-029 A shared package SHALL hold the state enum (BOOT, RUN), the default NOP_INSTR constant and the byte-lane order function.
REQ-030 One sub-module, instr_mem_array, SHALL hold the byte array, the word write port and the registered 4-byte read, plus the parity storage when the macro is enabled.

Verification
REQ-031 Scenario: after reset, load 0x00500093 at addr 0 and 0x00100113 at addr 4, then pulse load_done. Then PC=0 gives 0x00500093 with valid=1 one cycle later, and PC=4 gives 0x00100113.
REQ-032 Scenario: in RUN, PC=4 with hold=1 for 3 cycles. instruction stays at the pre-hold value for those 3 cycles. With flush=1 and hold=1 together, the result is NOP, valid=0.
REQ-033 Scenario: PC=2 gives misaligned=1 with NOP. PC=254 with DEPTH_BYTES=256 gives out_of_range=1 and misaligned=1. PC=32'hFFFFFFFC gives out_of_range=1.
REQ-034 Scenario: load_addr=6 or load_addr=256 gives a one-cycle load_err pulse and memory unchanged. load_en in RUN gives no write.
REQ-035 Scenario: with BIG_ENDIAN=0, a load of 0x11223344 at 0 stores byte 0 = 0x44. The fetch returns 0x11223344.
REQ-036 Scenario: nReset low mid-run gives instruction=NOP and ready=0 immediately, with no wait for a clock edge. After re-entering RUN, earlier memory contents are intact. With IMEM_PARITY_EN and a forced flipped bit, parity_err=1.
